// File: rtl/generador_secuencia.sv
// Serial word transmitter: sends a latched word MSB-first on x, repeated reps+1 times with one-cycle gaps.
// Define GENERADOR_PARIDAD_EN to append an even-parity bit to every word.
module generador_secuencia #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       reps,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
`ifdef GENERADOR_PARIDAD_EN
    localparam logic [BCW-1:0] BC_LOAD = BCW'(WIDTH);
`else
    localparam logic [BCW-1:0] BC_LOAD = BCW'(WIDTH - 1);
`endif

    // IDLE: waiting for start | SHIFT: bits on x | GAP: x=0 between words | DONE: done pulse
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BCW-1:0]   bc_q, bc_d;
    logic [3:0]       rc_q, rc_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        sh_d    = sh_q;
        bc_d    = bc_q;
        rc_d    = rc_q;
        x_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    dat_d   = data;
                    rc_d    = reps;
                    sh_d    = data;
                    x_d     = data[WIDTH-1];
                    bc_d    = BC_LOAD;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (bc_q == '0) begin
                    if (rc_q != 4'd0) begin
                        state_d = GAP;
                        rc_d    = rc_q - 4'd1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    sh_d   = sh_q << 1;
                    bc_d   = bc_q - BCW'(1);
                    busy_d = 1'b1;
                    x_d    = sh_q[WIDTH-2];
`ifdef GENERADOR_PARIDAD_EN
                    // The slot after the LSB carries the parity of the latched word.
                    if (bc_q == BCW'(1)) begin
                        x_d = ^dat_q;
                    end
`endif
                end
            end
            GAP: begin
                state_d = SHIFT;
                sh_d    = dat_q;
                x_d     = dat_q[WIDTH-1];
                bc_d    = BC_LOAD;
                busy_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            dat_q   <= '0;
            sh_q    <= '0;
            bc_q    <= '0;
            rc_q    <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            sh_q    <= sh_d;
            bc_q    <= bc_d;
            rc_q    <= rc_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_generador_secuencia.sv
// Directed bench for generador_secuencia (WIDTH=8); expected bit streams come from the sent word.
module tb_generador_secuencia;

    localparam int W = 8;
`ifdef GENERADOR_PARIDAD_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk;
    logic         r;
    logic         start;
    logic [W-1:0] data;
    logic [3:0]   reps;
    logic         x;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    generador_secuencia #(.WIDTH(W)) dut (
        .clk   (clk),
        .r     (r),
        .start (start),
        .data  (data),
        .reps  (reps),
        .x     (x),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one transmission and checks every cycle; poke>0 pulses start with new data at that cycle.
    task automatic send_check(input logic [W-1:0] d, input logic [3:0] n, input int poke);
        int b;
        int p;
        logic ex;
        logic [W-1:0] dd;
        dd = d;
        b = (int'(n) + 1) * F + int'(n);
        data = d;
        reps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= b; c++) begin
            p = (c - 1) % (F + 1);
            if (p >= F) ex = 1'b0;
            else if (p < W) ex = dd[W-1-p];
            else ex = ^dd;
            chk("x", 32'(x), 32'(ex));
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (c == poke) begin
                start = 1'b1;
                data  = '0;
                reps  = 4'd3;
            end
            if (c == poke + 1) start = 1'b0;
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("x_at_done", 32'(x), 32'd0);
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        tick();
        chk("busy_idle2", 32'(busy), 32'd0);
        chk("x_idle", 32'(x), 32'd0);
    endtask

    initial begin
        int seen;
        int bound_ok;
        checks   = 0;
        failures = 0;

        // reset wins over start
        r = 1'b1;
        start = 1'b1;
        data = 8'hA5;
        reps = 4'd0;
        tick();
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        chk("rst_x2", 32'(x), 32'd0);
        chk("rst_busy2", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        r = 1'b0;
        start = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        send_check(8'hA5, 4'd0, -1);
        send_check(8'hC3, 4'd2, -1);

        // abort on the 5th bit
        data = 8'hFF;
        reps = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("abort_pre_x", 32'(x), 32'd1);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        r = 1'b1;
        tick();
        r = 1'b0;
        chk("abort_x", 32'(x), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) seen++;
            tick();
        end
        chk("abort_silent", 32'(seen), 32'd0);
        send_check(8'h3C, 4'd1, -1);

        // start/data changes while shifting are ignored
        send_check(8'h96, 4'd0, 3);

        // start held high: restart on the edge after DONE
        data = 8'h81;
        reps = 4'd0;
        start = 1'b1;
        tick();
        for (int i = 0; i < F; i++) tick();
        chk("b2b_done", 32'(done), 32'd1);
        tick();
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_x", 32'(x), 32'd0);
        tick();
        start = 1'b0;
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_restart_x", 32'(x), 32'd1);
        bound_ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                bound_ok = 1;
                break;
            end
            tick();
        end
        chk("b2b_second_done", 32'(bound_ok), 32'd1);
        tick();
        tick();

`ifdef GENERADOR_PARIDAD_EN
        send_check(8'h07, 4'd0, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
